// File: rtl/rths_pkg.sv
// Shared RTHS definitions: record field positions, sort-direction encoding,
// frame-buffer state encoding and the pad-key helper.
package rths_pkg;

    localparam int REC_W   = 16;
    localparam int KEY_MSB = REC_W - 1;
    localparam int KEY_LSB = REC_W / 2;

    // Same meaning as the compare-exchange direction input.
    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

    // Key that sorts to the tail: max key when ascending, zero when descending.
    function automatic logic [31:0] pad_key(input logic dir, input int w);
        if (dir == DIR_DESC) begin
            return 32'h0;
        end
        return 32'hFFFF_FFFF >> (32 - w / 2);
    endfunction

endpackage

// File: rtl/rths_frame_loader_if.sv
// Record-stream input and frame output bundle of the RTHS frame loader.
interface rths_frame_loader_if #(
    parameter int W = 16,
    parameter int N = 8
);
    localparam int CW = $clog2(N) + 1;

    logic           direction;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic [CW-1:0]  out_count;
    logic           out_dir;

    // A transfer happens on a rising clock edge where valid & ready are both 1;
    // valid and its payload hold steady until that edge, ready never waits on valid.
    modport slave (
        input  direction, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_dir
    );

    modport master (
        output direction, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_dir
    );

endinterface

// File: rtl/rths_frame_buf.sv
// One frame buffer: slot writes, close-with-pad and clear, with an
// EMPTY/FILLING/FULL state machine whose state doubles as the full flag.
module rths_frame_buf
    import rths_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [$clog2(N)-1:0]     wr_idx_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     dir_i,
    input  logic                     close_i,
    input  logic                     clr_i,
    output logic [N*W-1:0]           data_o,
    output logic [$clog2(N):0]       count_o,
    output logic                     dir_o,
    output buf_state_e               state_o
);
    localparam int KW = W / 2;
    localparam int CW = $clog2(N) + 1;

    logic [N*W-1:0] data_q;
    logic [CW-1:0]  count_q;
    logic           dir_q;
    buf_state_e     state_q;
    logic           eff_dir;
    logic [KW-1:0]  pad_k;

    // A single-record frame closes in the same cycle its direction is latched.
    assign eff_dir = (wr_idx_i == '0) ? dir_i : dir_q;
    assign pad_k   = KW'(pad_key(eff_dir, W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            count_q <= '0;
            dir_q   <= DIR_ASC;
            state_q <= BUF_EMPTY;
        end else if (wr_en_i) begin
            data_q[int'(wr_idx_i)*W +: W] <= wr_data_i;
            if (wr_idx_i == '0) begin
                dir_q <= dir_i;
            end
            if (close_i) begin
                for (int s = 0; s < N; s++) begin
                    if (s > int'(wr_idx_i)) begin
                        data_q[s*W +: W] <= {pad_k, {KW{1'b0}}};
                    end
                end
                count_q <= CW'(wr_idx_i) + CW'(1);
                state_q <= BUF_FULL;
            end else begin
                state_q <= BUF_FILLING;
            end
        end else if (clr_i) begin
            state_q <= BUF_EMPTY;
        end
    end

    assign data_o  = data_q;
    assign count_o = count_q;
    assign dir_o   = dir_q;
    assign state_o = state_q;

endmodule

// File: rtl/rths_frame_loader.sv
// RTHS input stage: packs a serial record stream into N-wide padded frames
// through two ping-pong buffers so filling and draining overlap.
module rths_frame_loader
    import rths_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    rths_frame_loader_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N) + 1;

    logic           wsel_q;
    logic           rsel_q;
    logic [IW-1:0]  widx_q;

    logic [N*W-1:0] b_data  [2];
    logic [CW-1:0]  b_count [2];
    logic           b_dir   [2];
    buf_state_e     b_state [2];
    logic           b_full  [2];

    logic in_ready;
    logic in_fire;
    logic out_fire;
    logic close;

    assign in_ready = !b_full[wsel_q];
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = b_full[rsel_q] & bus.out_ready;
    assign close    = in_fire & (bus.in_last | (widx_q == IW'(N - 1)));

    for (genvar g = 0; g < 2; g++) begin : g_buf
        rths_frame_buf #(.W(W), .N(N)) u_buf (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (in_fire && (wsel_q == 1'(g))),
            .wr_idx_i  (widx_q),
            .wr_data_i (bus.in_data),
            .dir_i     (bus.direction),
            .close_i   (close),
            .clr_i     (out_fire && (rsel_q == 1'(g))),
            .data_o    (b_data[g]),
            .count_o   (b_count[g]),
            .dir_o     (b_dir[g]),
            .state_o   (b_state[g])
        );
        assign b_full[g] = (b_state[g] == BUF_FULL);
    end

    // A closing write and a drain always hit different buffers, so both pointers move freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            widx_q <= '0;
        end else begin
            if (in_fire) begin
                if (close) begin
                    widx_q <= '0;
                    wsel_q <= ~wsel_q;
                end else begin
                    widx_q <= widx_q + IW'(1);
                end
            end
            if (out_fire) begin
                rsel_q <= ~rsel_q;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = b_full[rsel_q];
    assign bus.out_data  = b_data[rsel_q];
    assign bus.out_count = b_count[rsel_q];
    assign bus.out_dir   = b_dir[rsel_q];

endmodule

// File: doc/rths_frame_loader.md
Name: rths_frame_loader

Overview:
- Upstream input stage of the RTHS sorter. Collects a serial stream of W-bit records into N-wide parallel frames for the compare-exchange network.
- Pads short frames with sentinel records, so padding always sorts to the tail for the frame's sort direction.
- Ping-pong double buffering: the input stream can run at one record per cycle while the sorter drains the other buffer.

Parameters:
- W, 16: record width. Record = {key[W-1:W/2], info[W/2-1:0]}. W must be even.
- N, 8: records per frame. Power of two, N >= 2.
- CW, $clog2(N)+1: width of out_count (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- direction  in  1  sort direction for the frame: 0 = ascending, 1 = descending. Sampled with the first record of each frame.
- in_valid  in  1  input record valid.
- in_ready  out  1  loader can accept a record.
- in_data  in  W  input record.
- in_last  in  1  marks the final record of a frame.
- out_valid  out  1  complete frame available.
- out_ready  in  1  sorter accepts the frame.
- out_data  out  N*W  frame. Slot i occupies [i*W +: W]; slot 0 is the first record received.
- out_count  out  CW  number of real (non-pad) records, 1..N.
- out_dir  out  1  direction latched for this frame.

Behaviour:
- Transfer rules:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - out_data, out_count and out_dir stay stable while out_valid=1 and out_ready=0.
- State: two buffers B0/B1, each with N*W data, a full flag, a count and a dir bit. Pointers:
  - wsel selects the fill buffer.
  - rsel selects the drain buffer.
  - widx (log2 N bits) is the next slot in the fill buffer.
- Per-buffer FSM: EMPTY -> FILLING (first record accepted) -> FULL (frame closed) -> EMPTY (output transfer).
- Port assignments:
  - in_ready = !full[wsel].
  - out_valid = full[rsel].
  - out_* are driven directly from buffer[rsel] registers.
- On an input transfer:
  - Write slot widx.
  - If widx==0, latch direction into dir[wsel].
  - If widx==N-1 or in_last, close the frame:
    - Fill slots widx+1..N-1 with the pad record. Key = all-ones if dir=0, all-zeros if dir=1; info = 0. Use the dir being latched this cycle when widx==0.
    - Set count = widx+1, set full[wsel], set widx=0, toggle wsel.
  - Otherwise widx++.
- Latency: out_valid rises the cycle after the closing input transfer, provided that buffer is the drain target (rsel). Zero bubble: a frame of N records is accepted in N consecutive cycles when out_ready is held high.
- On an output transfer: clear full[rsel] and toggle rsel.
- Simultaneous events: a closing input transfer and an output transfer in the same cycle act on different buffers and are both honoured. Buffer-full status is registered, so in_ready does not depend combinationally on out_ready.
- Both buffers full: in_ready=0 until an output transfer. in_ready reasserts the cycle after that transfer.
- in_last on the first record: count=1, slots 1..N-1 padded.
- A frame with no in_last closes automatically at N records. The next record starts a new frame.
- Reset (asynchronous assert, any time including mid-frame):
  - All buffer data = 0, full=0, counts=0, dirs=0, wsel=rsel=0, widx=0.
  - Hence out_valid=0, in_ready=1, out_data=0, out_count=0, out_dir=0.
  - A partially filled frame is discarded. Reset deassertion is synchronised externally.
- No arithmetic overflow: widx wraps to 0 only via frame close.

Decomposition:
- Shared package rths_pkg:
  - Record field helpers: KEY_MSB = W-1, KEY_LSB = W/2.
  - Direction constants DIR_ASC = 1'b0 and DIR_DESC = 1'b1, with the same meaning as the compare-exchange direction input.
  - Pad-key function pad_key(dir, W).
- One natural sub-module: rths_frame_buf, a single buffer holding data, count, dir and full, with write-slot, close-with-pad and clear controls. Instantiated twice, with ping-pong select logic in the parent.

Test Plan:
- Full frame, W=16, N=8, dir=0, records key=8..1 (info=key), out_ready=1 -> one frame: slot0 key 8 ... slot7 key 1, out_count=8, out_dir=0, out_valid 1 cycle after the 8th transfer.
- Short frame, dir=0, 3 records (keys 5, 2, 9), in_last on the 3rd -> slots 3..7 = 16'hFF00, out_count=3. Repeat with dir=1 -> pads 16'h0000, out_dir=1.
- Backpressure, out_ready=0, stream 20 records continuously -> in_ready drops after the 16th transfer. Both frames are held stable. Raising out_ready for 1 cycle -> frame 1 transfers, in_ready=1 the next cycle, and frame 2 is presented unchanged.
- Streaming with out_ready=1, 32 records -> 4 frames, zero input stall cycles, frames in order.
- Single-record frames: in_last every record, 4 records -> 4 frames, each out_count=1 with 7 pads.
- Reset after 5 records of a frame -> out_valid=0, in_ready=1, out_data=0. The next 8 records form a clean frame with no stale data.
